// File: rtl/pipe_ctrl_if.sv
// Control bundle between the hazard controller and the pipeline it steers.
// The core side drives the *_i requests; the controller drives the *_o controls.
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             jump_en_i;
    logic [31:0]      jump_addr_i;
    logic             load_use_i;
    logic             mc_start_i;
    logic             mc_done_i;

    logic             jump_en_o;
    logic [31:0]      jump_addr_o;
    logic             pc_stall_o;
    logic             if_id_stall_o;
    logic             id_ex_stall_o;
    logic             if_id_flush_o;
    logic             id_ex_flush_o;
    logic             mc_abort_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output jump_en_i, jump_addr_i, load_use_i, mc_start_i, mc_done_i,
        input  jump_en_o, jump_addr_o, pc_stall_o, if_id_stall_o, id_ex_stall_o,
        input  if_id_flush_o, id_ex_flush_o, mc_abort_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  jump_en_i, jump_addr_i, load_use_i, mc_start_i, mc_done_i,
        output jump_en_o, jump_addr_o, pc_stall_o, if_id_stall_o, id_ex_stall_o,
        output if_id_flush_o, id_ex_flush_o, mc_abort_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Stall/flush arbiter for the 5-stage core: EX redirects, load-use bubbles, multi-cycle EX ops.
// Define PIPE_CTRL_PERF_CNT_EN to build the saturating stall/flush performance counters.
module pipe_ctrl #(
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input logic        clk,
    input logic        rst_n,
    pipe_ctrl_if.slave bus
);

    localparam int unsigned TmoW = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(MC_TIMEOUT - 1);

    typedef enum logic [0:0] {
        StRun,
        StBusy
    } state_e;

    state_e          state_q, state_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            abort_q, abort_d;

    logic            jump_en;
    logic            pc_stall;
    logic            if_id_stall;
    logic            id_ex_stall;
    logic            if_id_flush;
    logic            id_ex_flush;

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        abort_d     = 1'b0;
        jump_en     = 1'b0;
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        id_ex_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        unique case (state_q)
            StRun: begin
                if (abort_q) begin
                    // Timed-out op is dropped: bubble into ID/EX, ignore new requests.
                    id_ex_flush = 1'b1;
                end else if (bus.jump_en_i) begin
                    jump_en     = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (bus.mc_start_i && !bus.mc_done_i) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_stall = 1'b1;
                    state_d     = StBusy;
                    tmo_d       = '0;
                end else if (bus.load_use_i) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
            StBusy: begin
                if (bus.mc_done_i) begin
                    state_d = StRun;
                end else begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_stall = 1'b1;
                    tmo_d       = tmo_q + 1'b1;
                    if (tmo_d == TmoLast) begin
                        state_d = StRun;
                        abort_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StRun;
            tmo_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            abort_q <= abort_d;
        end
    end

    // Every control is held low while reset is asserted, even before the first edge.
    assign bus.jump_en_o     = rst_n & jump_en;
    assign bus.jump_addr_o   = (rst_n && jump_en) ? bus.jump_addr_i : 32'h0;
    assign bus.pc_stall_o    = rst_n & pc_stall;
    assign bus.if_id_stall_o = rst_n & if_id_stall;
    assign bus.id_ex_stall_o = rst_n & id_ex_stall;
    assign bus.if_id_flush_o = rst_n & if_id_flush;
    assign bus.id_ex_flush_o = rst_n & id_ex_flush;
    assign bus.mc_abort_o    = rst_n & abort_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_stall && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if ((if_id_flush || id_ex_flush) && !(&flush_cnt_q)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign bus.stall_cnt_o = rst_n ? stall_cnt_q : '0;
    assign bus.flush_cnt_o = rst_n ? flush_cnt_q : '0;
`else
    assign bus.stall_cnt_o = '0;
    assign bus.flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed test-plan sequences followed by random traffic.
module tb_pipe_ctrl;

    localparam int unsigned MC_TIMEOUT = 8;
    localparam int unsigned CNT_W      = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_ctrl #(
        .MC_TIMEOUT(MC_TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic             jump_en;
        logic [31:0]      jump_addr;
        logic             pc_stall;
        logic             if_id_stall;
        logic             id_ex_stall;
        logic             if_id_flush;
        logic             id_ex_flush;
        logic             abort;
        logic [CNT_W-1:0] scnt;
        logic [CNT_W-1:0] fcnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: whether an op is outstanding, how many cycles it has stalled so far,
    // whether an abort is owed next cycle, and the running counts.
    bit m_busy  = 0;
    int m_held  = 0;
    bit m_abort = 0;
    int m_scnt  = 0;
    int m_fcnt  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input bit rst, input bit jmp, input logic [31:0] addr, input bit lu,
                        input bit st, input bit dn);
        exp_t e;
        int   cmax;
        cmax = (1 << CNT_W) - 1;
        @(posedge clk);
        #1;
        rst_n           = rst;
        bus.jump_en_i   = jmp;
        bus.jump_addr_i = addr;
        bus.load_use_i  = lu;
        bus.mc_start_i  = st;
        bus.mc_done_i   = dn;

        e = '{default: '0};
        if (rst) begin
`ifdef PIPE_CTRL_PERF_CNT_EN
            e.scnt = CNT_W'(m_scnt);
            e.fcnt = CNT_W'(m_fcnt);
`endif
            if (m_abort) begin
                e.abort       = 1;
                e.id_ex_flush = 1;
            end else if (m_busy) begin
                e.pc_stall    = !dn;
                e.if_id_stall = !dn;
                e.id_ex_stall = !dn;
            end else if (jmp) begin
                e.jump_en     = 1;
                e.jump_addr   = addr;
                e.if_id_flush = 1;
                e.id_ex_flush = 1;
            end else if (st && !dn) begin
                e.pc_stall    = 1;
                e.if_id_stall = 1;
                e.id_ex_stall = 1;
            end else if (lu) begin
                e.pc_stall    = 1;
                e.if_id_stall = 1;
                e.id_ex_flush = 1;
            end
        end
        exp_q.push_back(e);

        if (!rst) begin
            m_busy  = 0;
            m_held  = 0;
            m_abort = 0;
            m_scnt  = 0;
            m_fcnt  = 0;
        end else begin
            if (e.pc_stall && m_scnt < cmax) m_scnt++;
            if ((e.if_id_flush || e.id_ex_flush) && m_fcnt < cmax) m_fcnt++;
            if (m_abort) begin
                m_abort = 0;
            end else if (m_busy) begin
                if (dn) begin
                    m_busy = 0;
                end else begin
                    m_held++;
                    if (m_held == MC_TIMEOUT) begin
                        m_busy  = 0;
                        m_abort = 1;
                    end
                end
            end else if (!jmp && st && !dn) begin
                m_busy = 1;
                m_held = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 32'h0, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents a full set of controls; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("jump_en",     bus.jump_en_o,     e.jump_en);
                chk("jump_addr",   bus.jump_addr_o,   e.jump_addr);
                chk("pc_stall",    bus.pc_stall_o,    e.pc_stall);
                chk("if_id_stall", bus.if_id_stall_o, e.if_id_stall);
                chk("id_ex_stall", bus.id_ex_stall_o, e.id_ex_stall);
                chk("if_id_flush", bus.if_id_flush_o, e.if_id_flush);
                chk("id_ex_flush", bus.id_ex_flush_o, e.id_ex_flush);
                chk("mc_abort",    bus.mc_abort_o,    e.abort);
                chk("stall_cnt",   bus.stall_cnt_o,   e.scnt);
                chk("flush_cnt",   bus.flush_cnt_o,   e.fcnt);
                chk("flush_stall_overlap",
                    (bus.if_id_flush_o & bus.if_id_stall_o) | (bus.id_ex_flush_o & bus.id_ex_stall_o),
                    1'b0);
            end
        end
    end

    initial begin
        bus.jump_en_i   = 0;
        bus.jump_addr_i = 0;
        bus.load_use_i  = 0;
        bus.mc_start_i  = 0;
        bus.mc_done_i   = 0;

        // Reset held with a jump request: nothing may leak out.
        for (int i = 0; i < 3; i++) step(0, 1, 32'h0000_0100, 0, 0, 0);
        idle(2);

        // Jump wins over a simultaneous load-use.
        step(1, 1, 32'h0000_0100, 1, 0, 0);
        idle(1);

        // Single load-use bubble, counters visible afterwards.
        step(1, 0, 32'h0, 1, 0, 0);
        idle(2);

        // 6-cycle op with a jump in the middle that must be ignored.
        step(1, 0, 32'h0, 0, 1, 0);
        idle(1);
        step(1, 1, 32'hdead_beef, 1, 1, 0);
        idle(2);
        step(1, 0, 32'h0, 0, 0, 1);
        idle(1);

        // Zero-latency op.
        step(1, 0, 32'h0, 0, 1, 1);
        idle(1);

        // Timeout with a start request during the abort cycle.
        step(1, 0, 32'h0, 0, 1, 0);
        idle(MC_TIMEOUT - 1);
        step(1, 0, 32'h0, 1, 1, 0);
        idle(2);

        // Reset in the middle of an op, then a stale done.
        step(1, 0, 32'h0, 0, 1, 0);
        idle(2);
        step(0, 0, 32'h0, 0, 0, 0);
        step(1, 0, 32'h0, 0, 0, 1);
        idle(2);

        // Random traffic; counters saturate quickly at this width.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 79) != 0,
                 $urandom_range(0, 9) == 0,
                 $urandom(),
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 5) == 0);
        end
        idle(2);

        @(posedge clk);
        @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
